pipelined_variable_circular_rotator: RTL and testbench

// - Streaming barrel rotator: rotates an N-bit word left or right by a
//   run-time amount (0..N-1).
// - log2(N) registered stages; stage k conditionally rotates by 2**k.
// - valid/ready handshake on both sides; throughput 1 word/cycle.
// - Sits between a producer and consumer of packed words. A left

---
 rtl/rotator_pkg.sv | 41 ++++
 rtl/circular_rotate_stage.sv | 59 +++++
 rtl/pipelined_variable_circular_rotator.sv | 63 ++++++
 tb/tb_pipelined_variable_circular_rotator.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rotator_pkg.sv
// Shared types and bit-level reference rotations for the circular rotator.
// rotl/rotr work on any width up to MAX_N; only the low n bits are meaningful.
package rotator_pkg;

   typedef enum logic {
      ROT_LEFT  = 1'b0,
      ROT_RIGHT = 1'b1
   } rot_dir_e;

   localparam int MAX_N  = 64;
   localparam int MAX_AW = 6;

   function automatic logic [MAX_N-1:0] rotl(input logic [MAX_N-1:0] data,
                                             input int amount, input int n);
      logic [MAX_N-1:0]  r;
      logic [MAX_AW-1:0] src;
      logic [MAX_AW-1:0] dst;
      r = '0;
      for (int i = 0; i < n; i++) begin
         src    = MAX_AW'(i);
         dst    = MAX_AW'((i + amount) % n);
         r[dst] = data[src];
      end
      return r;
   endfunction

   function automatic logic [MAX_N-1:0] rotr(input logic [MAX_N-1:0] data,
                                             input int amount, input int n);
      logic [MAX_N-1:0]  r;
      logic [MAX_AW-1:0] src;
      logic [MAX_AW-1:0] dst;
      r = '0;
      for (int i = 0; i < n; i++) begin
         src    = MAX_AW'(i);
         dst    = MAX_AW'((i + n - (amount % n)) % n);
         r[dst] = data[src];
      end
      return r;
   endfunction

endpackage

// File: rtl/circular_rotate_stage.sv
// One registered rotator stage: rotates by SHIFT when its amount bit is set,
// with a valid/ready slot that reloads whenever it is empty or draining.
module circular_rotate_stage
   import rotator_pkg::*;
#(
   parameter  int N     = 8,
   parameter  int SHIFT = 1,
   localparam int W     = $clog2(N),
   localparam int BIT   = $clog2(SHIFT)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         up_valid,
   output logic         up_ready,
   input  logic [N-1:0] up_data,
   input  logic [W-1:0] up_amount,
   input  logic         up_dir,
   output logic         down_valid,
   input  logic         down_ready,
   output logic [N-1:0] down_data,
   output logic [W-1:0] down_amount,
   output logic         down_dir
);

   logic         vld_p;
   logic [N-1:0] data_p;
   logic [W-1:0] amount_p;
   logic         dir_p;

   function automatic logic [N-1:0] rotate_by_shift(input logic [N-1:0] d,
                                                    input logic dir);
      if (dir == ROT_RIGHT)
         return {d[SHIFT-1:0], d[N-1:SHIFT]};
      return {d[N-1-SHIFT:0], d[N-1:N-SHIFT]};
   endfunction

   assign up_ready = !vld_p || down_ready;

   // stage boundary: a bubble (up_valid = 0) still loads, carrying don't-care data
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p    <= 1'b0;
         data_p   <= '0;
         amount_p <= '0;
         dir_p    <= 1'b0;
      end else if (up_ready) begin
         vld_p    <= up_valid;
         data_p   <= up_amount[BIT] ? rotate_by_shift(up_data, up_dir) : up_data;
         amount_p <= up_amount;
         dir_p    <= up_dir;
      end
   end

   assign down_valid  = vld_p;
   assign down_data   = data_p;
   assign down_amount = amount_p;
   assign down_dir    = dir_p;

endmodule

// File: rtl/pipelined_variable_circular_rotator.sv
// Streaming barrel rotator: W = log2(N) registered stages, stage k rotating
// by 2**k, chained with valid/ready so throughput is one word per cycle.
module pipelined_variable_circular_rotator
   import rotator_pkg::*;
#(
   parameter  int N = 8,
   localparam int W = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         up_valid,
   output logic         up_ready,
   input  logic [N-1:0] up_data,
   input  logic [W-1:0] up_amount,
   input  logic         up_dir,
   output logic         down_valid,
   input  logic         down_ready,
   output logic [N-1:0] down_data
);

   // index k is the input side of stage k; index W is the pipeline output
   logic         vld_p  [0:W];
   logic         rdy_p  [0:W];
   logic [N-1:0] data_p [0:W];
   logic [W-1:0] amt_p  [0:W];
   logic         dir_p  [0:W];
   logic         unused_tail;

   assign vld_p[0]  = up_valid;
   assign data_p[0] = up_data;
   assign amt_p[0]  = up_amount;
   assign dir_p[0]  = up_dir;
   assign up_ready  = rdy_p[0];

   assign rdy_p[W]   = down_ready;
   assign down_valid = vld_p[W];
   assign down_data  = data_p[W];

   assign unused_tail = ^{amt_p[W], dir_p[W]};

   generate
      for (genvar k = 0; k < W; k++) begin : g_stage
         circular_rotate_stage #(
            .N     (N),
            .SHIFT (2 ** k)
         ) u_stage (
            .clk         (clk),
            .rst         (rst),
            .up_valid    (vld_p[k]),
            .up_ready    (rdy_p[k]),
            .up_data     (data_p[k]),
            .up_amount   (amt_p[k]),
            .up_dir      (dir_p[k]),
            .down_valid  (vld_p[k+1]),
            .down_ready  (rdy_p[k+1]),
            .down_data   (data_p[k+1]),
            .down_amount (amt_p[k+1]),
            .down_dir    (dir_p[k+1])
         );
      end
   endgenerate

endmodule

// File: tb/tb_pipelined_variable_circular_rotator.sv
// Bench for the pipelined circular rotator (N = 8): directed vectors, random
// streaming, backpressure, round trip and mid-stream reset against a model.
module tb_pipelined_variable_circular_rotator;
   import rotator_pkg::*;

   localparam int N = 8;
   localparam int W = 3;

   logic         clk = 1'b0;
   logic         rst;
   logic         up_valid;
   logic         up_ready;
   logic [N-1:0] up_data;
   logic [W-1:0] up_amount;
   logic         up_dir;
   logic         down_valid;
   logic         down_ready;
   logic [N-1:0] down_data;

   int tests_run = 0;
   int failed    = 0;

   always #5 clk = ~clk;

   pipelined_variable_circular_rotator #(.N(N)) dut (
      .clk        (clk),
      .rst        (rst),
      .up_valid   (up_valid),
      .up_ready   (up_ready),
      .up_data    (up_data),
      .up_amount  (up_amount),
      .up_dir     (up_dir),
      .down_valid (down_valid),
      .down_ready (down_ready),
      .down_data  (down_data)
   );

   // rotation as a shift of the word concatenated with itself
   function automatic logic [7:0] model_rot(input logic [7:0] d, input int s,
                                            input logic dir);
      logic [15:0] x;
      x = {d, d};
      if (dir) begin
         x = x >> s;
         return x[7:0];
      end
      x = x << s;
      return x[15:8];
   endfunction

   // send one word into an idle pipe and wait for its result
   task automatic xfer(input logic [7:0] d, input int s, input logic dir,
                       output logic [7:0] res, output int lat);
      up_data    = d;
      up_amount  = W'(s);
      up_dir     = dir;
      up_valid   = 1'b1;
      down_ready = 1'b1;
      @(posedge clk); #1;
      up_valid = 1'b0;
      lat = -1;
      res = '0;
      for (int c = 1; c <= 10; c++) begin
         if (down_valid) begin
            lat = c;
            res = down_data;
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      rst        = 1'b1;
      up_valid   = 1'b0;
      up_data    = '0;
      up_amount  = '0;
      up_dir     = 1'b0;
      down_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      tests_run++;
      if (down_valid !== 1'b0) begin
         failed++;
         $display("FAIL reset_down_valid: got %b want 0", down_valid);
      end
      tests_run++;
      if (down_data !== 8'h00) begin
         failed++;
         $display("FAIL reset_down_data: got %h want 00", down_data);
      end
      tests_run++;
      if (up_ready !== 1'b1) begin
         failed++;
         $display("FAIL reset_up_ready: got %b want 1", up_ready);
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_fixed_vectors();
      logic [7:0] td  [4] = '{8'hA3, 8'hA3, 8'hA3, 8'hA3};
      int         ts  [4] = '{3, 3, 0, 0};
      logic       tdr [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      logic [7:0] te  [4] = '{8'h74, 8'h1D, 8'hA3, 8'hA3};
      logic [7:0] res;
      int         lat;
      for (int i = 0; i < 4; i++) begin
         xfer(td[i], ts[i], tdr[i], res, lat);
         tests_run++;
         if (lat !== 3) begin
            failed++;
            $display("FAIL fixed_latency[%0d]: got %0d cycles want 3", i, lat);
         end
         tests_run++;
         if (res !== te[i]) begin
            failed++;
            $display("FAIL fixed_data[%0d]: got %h want %h", i, res, te[i]);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_streaming();
      logic [7:0]  expq[$];
      logic [63:0] wide;
      logic [7:0]  exp_d;
      int sent  = 0;
      int recv  = 0;
      int first = -1;
      down_ready = 1'b1;
      for (int cyc = 0; cyc < 60 && recv < 16; cyc++) begin
         if (sent < 16) begin
            up_valid  = 1'b1;
            up_data   = 8'($urandom);
            up_amount = W'($urandom_range(0, 7));
            up_dir    = 1'($urandom_range(0, 1));
         end else begin
            up_valid = 1'b0;
         end
         #1;
         if (up_valid) begin
            tests_run++;
            if (up_ready !== 1'b1) begin
               failed++;
               $display("FAIL stream_up_ready: cycle %0d got %b want 1", cyc, up_ready);
            end
         end
         if (up_valid && up_ready) begin
            wide = up_dir ? rotr(64'(up_data), int'(up_amount), N)
                          : rotl(64'(up_data), int'(up_amount), N);
            expq.push_back(wide[7:0]);
            sent++;
         end
         if (down_valid && down_ready) begin
            if (first < 0) first = cyc;
            exp_d = (expq.size() > 0) ? expq.pop_front() : 8'hxx;
            tests_run++;
            if (down_data !== exp_d || cyc != first + recv) begin
               failed++;
               $display("FAIL stream_out[%0d]: got %h at cycle %0d want %h at cycle %0d",
                        recv, down_data, cyc, exp_d, first + recv);
            end
            recv++;
         end
         @(posedge clk); #1;
      end
      up_valid = 1'b0;
      tests_run++;
      if (recv != 16) begin
         failed++;
         $display("FAIL stream_count: got %0d results want 16", recv);
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] expq[$];
      logic [7:0] exp_d;
      logic [7:0] stable_d = '0;
      logic       have_stable = 1'b0;
      logic       pend = 1'b0;
      int sent = 0;
      int recv = 0;
      for (int cyc = 0; cyc < 80 && recv < 8; cyc++) begin
         down_ready = (cyc >= 5);
         if (sent < 8) begin
            if (!pend) begin
               up_data   = 8'($urandom);
               up_amount = W'($urandom_range(0, 7));
               up_dir    = 1'($urandom_range(0, 1));
               pend      = 1'b1;
            end
            up_valid = 1'b1;
         end else begin
            up_valid = 1'b0;
         end
         #1;
         if (cyc < 5) begin
            tests_run++;
            if (up_ready !== (sent < 3)) begin
               failed++;
               $display("FAIL bp_up_ready: cycle %0d got %b want %b", cyc, up_ready, sent < 3);
            end
            if (down_valid) begin
               if (have_stable) begin
                  tests_run++;
                  if (down_data !== stable_d) begin
                     failed++;
                     $display("FAIL bp_stable: cycle %0d got %h want %h", cyc, down_data, stable_d);
                  end
               end
               stable_d    = down_data;
               have_stable = 1'b1;
            end
         end
         if (up_valid && up_ready) begin
            expq.push_back(model_rot(up_data, int'(up_amount), up_dir));
            sent++;
            pend = 1'b0;
         end
         if (down_valid && down_ready) begin
            exp_d = (expq.size() > 0) ? expq.pop_front() : 8'hxx;
            tests_run++;
            if (down_data !== exp_d) begin
               failed++;
               $display("FAIL bp_out[%0d]: got %h want %h", recv, down_data, exp_d);
            end
            recv++;
         end
         @(posedge clk); #1;
      end
      up_valid = 1'b0;
      tests_run++;
      if (recv != 8 || expq.size() != 0) begin
         failed++;
         $display("FAIL bp_count: got %0d results (%0d left) want 8 (0 left)", recv, expq.size());
      end
   endtask

   task automatic test_round_trip();
      logic [7:0] d, y, z;
      int         lat1, lat2;
      for (int s = 0; s < 8; s++) begin
         d = 8'($urandom);
         xfer(d, s, 1'b0, y, lat1);
         xfer(y, s, 1'b1, z, lat2);
         tests_run++;
         if (y !== model_rot(d, s, 1'b0) || lat1 < 0) begin
            failed++;
            $display("FAIL rt_left[%0d]: got %h want %h", s, y, model_rot(d, s, 1'b0));
         end
         tests_run++;
         if (z !== d || lat2 < 0) begin
            failed++;
            $display("FAIL rt_back[%0d]: got %h want %h", s, z, d);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_midstream();
      logic [7:0] res;
      int         lat;
      int         stale = 0;
      up_valid   = 1'b0;
      down_ready = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
      end
      for (int i = 0; i < 3; i++) begin
         up_valid  = 1'b1;
         up_data   = 8'($urandom);
         up_amount = W'($urandom_range(0, 7));
         up_dir    = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
      end
      up_valid = 1'b0;
      tests_run++;
      if (down_valid !== 1'b1 || up_ready !== 1'b0) begin
         failed++;
         $display("FAIL mid_full: got valid %b ready %b want valid 1 ready 0", down_valid, up_ready);
      end
      rst = 1'b1;
      #1;
      tests_run++;
      if (down_valid !== 1'b0 || down_data !== 8'h00) begin
         failed++;
         $display("FAIL mid_reset_async: got valid %b data %h want 0 00", down_valid, down_data);
      end
      @(posedge clk); #1;
      rst        = 1'b0;
      down_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         if (down_valid) stale++;
         @(posedge clk); #1;
      end
      tests_run++;
      if (stale != 0) begin
         failed++;
         $display("FAIL mid_stale: got %0d stale results want 0", stale);
      end
      xfer(8'h5A, 1, 1'b0, res, lat);
      tests_run++;
      if (res !== 8'hB4 || lat !== 3) begin
         failed++;
         $display("FAIL mid_recover: got %h after %0d cycles want b4 after 3", res, lat);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_fixed_vectors();
      test_streaming();
      test_backpressure();
      test_round_trip();
      test_reset_midstream();
      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end

endmodule
